// File: rtl/caja_musical_pkg.sv
// Shared definitions for the music box sequencer: entry layout, FSM encoding
// and 12 MHz half-period dividers for the fourth-octave notes.
package caja_musical_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LEE  = 2'd1,
        TOCA = 2'd2
    } estado_t;

    // Entry layout is {div, dur}: dur sits at bit 0 and div starts at DUR_W.
    localparam int DUR_W_DEF = 4;
    localparam int DUR_LSB   = 0;
    localparam int DIV_LSB   = DUR_W_DEF;

    localparam logic [15:0] DO4  = 16'd22933;
    localparam logic [15:0] RE4  = 16'd20431;
    localparam logic [15:0] MI4  = 16'd18202;
    localparam logic [15:0] FA4  = 16'd17180;
    localparam logic [15:0] SOL4 = 16'd15306;
    localparam logic [15:0] LA4  = 16'd13636;
    localparam logic [15:0] SI4  = 16'd12148;

endpackage

// File: rtl/caja_musical_seq_generador_tono.sv
// Square-wave tone generator: toggles every freq clocks, held low while
// cleared or when freq is zero (rest).
module generador_tono #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [DIV_W-1:0] freq,
    output logic             tono
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             tono_q, tono_d;

    // Half-period counter; the >= compare recovers cleanly if freq shrinks mid-count.
    always_comb begin
        cnt_d  = cnt_q;
        tono_d = tono_q;
        if (clr || (freq == '0)) begin
            cnt_d  = '0;
            tono_d = 1'b0;
        end else if (cnt_q >= (freq - DIV_W'(1))) begin
            cnt_d  = '0;
            tono_d = ~tono_q;
        end else begin
            cnt_d  = cnt_q + DIV_W'(1);
        end
    end

    // Counter and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tono_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tono_q <= tono_d;
        end
    end

    assign tono = tono_q;

endmodule

// File: rtl/caja_musical_seq.sv
// Programmable music box sequencer: writable {div, dur} note memory, rests,
// looping and start/stop control. Define VOLUMEN_PWM_EN to add PWM volume.
module caja_musical_seq
    import caja_musical_pkg::*;
#(
    parameter int N_NOTAS  = 32,
    parameter int IDX_W    = 5,
    parameter int DIV_W    = 16,
    parameter int DUR_W    = 4,
    parameter int TICK_DIV = 1200000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   inicio,
    input  logic                   detener,
    input  logic                   bucle,
    input  logic                   we,
    input  logic [IDX_W-1:0]       waddr,
    input  logic [DIV_W+DUR_W-1:0] wdata,
`ifdef VOLUMEN_PWM_EN
    input  logic [2:0]             volumen,
`endif
    output logic                   parlante,
    output logic [IDX_W-1:0]       indice_nota,
    output logic [DIV_W-1:0]       freq,
    output logic                   ocupado,
    output logic                   fin
);

    localparam int                ENT_W    = DIV_W + DUR_W;
    localparam int                DIV_OFS  = DUR_LSB + DUR_W;
    localparam int                TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(N_NOTAS - 1);

    logic [ENT_W-1:0]  mem_q [N_NOTAS];
    logic [ENT_W-1:0]  rdata_q;
    logic [DIV_W-1:0]  ent_div_s;
    logic [DUR_W-1:0]  ent_dur_s;

    estado_t           state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DIV_W-1:0]  freq_q, freq_d;
    logic [DUR_W-1:0]  dur_q, dur_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic              fin_q, fin_d;
    logic              ocupado_q, ocupado_d;
    logic              clr_s;
    logic              tono_s;

    // Note memory write port; contents survive reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read is addressed by the next index so the entry is ready in the LEE cycle
    always_ff @(posedge clk) begin
        rdata_q <= mem_q[idx_d];
    end

    assign ent_div_s = rdata_q[DIV_OFS +: DIV_W];
    assign ent_dur_s = rdata_q[DUR_LSB +: DUR_W];

    // Sequencer next-state logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        freq_d  = freq_q;
        dur_d   = dur_q;
        tick_d  = tick_q;
        fin_d   = 1'b0;
        if (detener) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (inicio) begin
                        state_d = LEE;
                        idx_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                LEE: begin
                    freq_d = ent_div_s;
                    dur_d  = ent_dur_s;
                    tick_d = '0;
                    if (ent_dur_s != '0) begin
                        state_d = TOCA;
                    end else if (bucle && (idx_q != '0)) begin
                        // the idx!=0 guard stops an all-marker melody from spinning
                        state_d = LEE;
                        idx_d   = '0;
                    end else begin
                        state_d = IDLE;
                        fin_d   = 1'b1;
                    end
                end
                TOCA: begin
                    if (tick_q != TICK_MAX) begin
                        tick_d = tick_q + TICK_W'(1);
                    end else begin
                        tick_d = '0;
                        dur_d  = dur_q - DUR_W'(1);
                        if (dur_q != DUR_W'(1)) begin
                            state_d = TOCA;
                        end else if (idx_q != IDX_LAST) begin
                            state_d = LEE;
                            idx_d   = idx_q + IDX_W'(1);
                        end else if (bucle) begin
                            state_d = LEE;
                            idx_d   = '0;
                        end else begin
                            state_d = IDLE;
                            fin_d   = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        ocupado_d = (state_d != IDLE);
        // silence the tone from the edge a note ends so every note starts low
        clr_s = (state_q != TOCA) || (state_d != TOCA);
    end

    // Sequencer state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            freq_q    <= '0;
            dur_q     <= '0;
            tick_q    <= '0;
            fin_q     <= 1'b0;
            ocupado_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            freq_q    <= freq_d;
            dur_q     <= dur_d;
            tick_q    <= tick_d;
            fin_q     <= fin_d;
            ocupado_q <= ocupado_d;
        end
    end

    generador_tono #(
        .DIV_W (DIV_W)
    ) u_tono (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr_s),
        .freq (freq_q),
        .tono (tono_s)
    );

`ifdef VOLUMEN_PWM_EN
    logic [2:0] pwm_q;

    // Free-running PWM phase for volume gating
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_q <= 3'd0;
        end else begin
            pwm_q <= pwm_q + 3'd1;
        end
    end

    assign parlante = tono_s & (pwm_q < volumen);
`else
    assign parlante = tono_s;
`endif

    assign indice_nota = idx_q;
    assign freq        = freq_q;
    assign ocupado     = ocupado_q;
    assign fin         = fin_q;

endmodule

// File: tb/tb_caja_musical_seq.sv
// Bench for caja_musical_seq: directed scenarios with random melodies, checked
// every cycle against a note-position reference model.
module tb_caja_musical_seq;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int DW = 16;
    localparam int UW = 4;
    localparam int T  = 10;

    logic             clk;
    logic             rst;
    logic             inicio;
    logic             detener;
    logic             bucle;
    logic             we;
    logic [IW-1:0]    waddr;
    logic [DW+UW-1:0] wdata;
    logic             parlante;
    logic [IW-1:0]    indice_nota;
    logic [DW-1:0]    freq;
    logic             ocupado;
    logic             fin;
`ifdef VOLUMEN_PWM_EN
    logic [2:0]       volumen;
`endif

    caja_musical_seq #(
        .N_NOTAS (N),
        .IDX_W   (IW),
        .DIV_W   (DW),
        .DUR_W   (UW),
        .TICK_DIV(T)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .inicio     (inicio),
        .detener    (detener),
        .bucle      (bucle),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
`ifdef VOLUMEN_PWM_EN
        .volumen    (volumen),
`endif
        .parlante   (parlante),
        .indice_nota(indice_nota),
        .freq       (freq),
        .ocupado    (ocupado),
        .fin        (fin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Reference model: the melody as the bench wrote it, plus where playback
    // stands: note index and cycle position inside the note (0 = read cycle).
    int m_mem_div [N];
    int m_mem_dur [N];
    bit m_busy = 1'b0;
    bit m_fin  = 1'b0;
    int m_idx  = 0;
    int m_k    = 0;
    int m_div  = 0;
    int m_dur  = 0;
    int m_freq = 0;
    int m_lee_div = 0;
    int m_lee_dur = 0;
    int m_pwm  = 0;

    task automatic go_lee(input int j);
        m_idx     = j;
        m_k       = 0;
        m_lee_div = m_mem_div[j];
        m_lee_dur = m_mem_dur[j];
    endtask

    task automatic end_of_melody(input bit may_loop);
        if (bucle && may_loop) go_lee(0);
        else begin
            m_busy = 1'b0;
            m_fin  = 1'b1;
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m_busy = 1'b0; m_fin = 1'b0; m_idx = 0; m_k = 0; m_freq = 0; m_pwm = 0;
        end else begin
            m_pwm = (m_pwm + 1) % 8;
            m_fin = 1'b0;
            if (detener) m_busy = 1'b0;
            else if (!m_busy) begin
                if (inicio) begin
                    m_busy = 1'b1;
                    go_lee(0);
                end
            end else if (m_k == 0) begin
                m_div  = m_lee_div;
                m_dur  = m_lee_dur;
                m_freq = m_lee_div;
                if (m_dur == 0) end_of_melody(m_idx != 0);
                else m_k = 1;
            end else if (m_k == m_dur * T) begin
                if (m_idx == N - 1) end_of_melody(1'b1);
                else go_lee(m_idx + 1);
            end else m_k++;
        end
        if (we) begin
            m_mem_div[waddr] = int'(wdata[DW+UW-1:UW]);
            m_mem_dur[waddr] = int'(wdata[UW-1:0]);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic chk_all();
        bit tone;
        tone = m_busy && (m_k >= 1) && (m_div != 0) && ((((m_k - 1) / m_div) % 2) == 1);
`ifdef VOLUMEN_PWM_EN
        tone = tone && (m_pwm < int'(volumen));
`endif
        chk("parlante", 32'(parlante), 32'(tone));
        chk("indice_nota", 32'(indice_nota), 32'(m_idx));
        chk("freq", 32'(freq), 32'(m_freq));
        chk("ocupado", 32'(ocupado), 32'(m_busy));
        chk("fin", 32'(fin), 32'(m_fin));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr(input int a, input int dv, input int du);
        we    = 1'b1;
        waddr = a[IW-1:0];
        wdata = {dv[DW-1:0], du[UW-1:0]};
        step();
        we    = 1'b0;
    endtask

    task automatic pulse_inicio();
        inicio = 1'b1;
        step();
        inicio = 1'b0;
    endtask

    task automatic pulse_detener();
        detener = 1'b1;
        step();
        detener = 1'b0;
    endtask

    int n;

    initial begin
        rst = 1'b1; inicio = 1'b0; detener = 1'b0; bucle = 1'b0;
        we = 1'b0; waddr = '0; wdata = '0;
`ifdef VOLUMEN_PWM_EN
        volumen = 3'd7;
`endif
        for (int i = 0; i < N; i++) begin
            m_mem_div[i] = 0;
            m_mem_dur[i] = 0;
        end
        run(2);
        rst = 1'b0;
        run(2);

        // Basic play with rest and end marker; fixed total length
        wr(0, 5, 2); wr(1, 3, 1); wr(2, 0, 1); wr(3, int'($urandom_range(1, 9)), 0);
        bucle = 1'b0;
        pulse_inicio();
        n = 1;
        while (ocupado === 1'b1 && n < 100) begin
            step();
            n++;
        end
        chk("basic_len", 32'(n), 32'd45);
        run(3);

        // Random melodies, random loop flag
        for (int r = 0; r < 4; r++) begin
            for (int a = 0; a < N; a++)
                wr(a, int'($urandom_range(0, 6)), int'($urandom_range(0, 3)));
            bucle = 1'($urandom_range(0, 1));
            pulse_inicio();
            run(60);
            pulse_inicio();
            run(70);
            pulse_detener();
            run(2);
        end

        // Loop of identical notes, then live write of entry 1 while it plays
        for (int a = 0; a < N; a++) wr(a, 4, 1);
        bucle = 1'b1;
        pulse_inicio();
        run(60);
        n = 0;
        while (!(m_idx == 1 && m_k == 3) && n < 60) begin
            step();
            n++;
        end
        chk("live_sync", 32'(n < 60), 32'd1);
        wr(1, 7, 1);
        run(60);

        // Stop and start in the same cycle mid-note: stop wins
        detener = 1'b1; inicio = 1'b1;
        step();
        detener = 1'b0; inicio = 1'b0;
        run(4);
        pulse_inicio();
        run(30);

        // Reset held for 3 cycles mid-play
        rst = 1'b1;
        run(3);
        rst = 1'b0;
        run(3);
        pulse_inicio();
        run(15);
        pulse_detener();

        // All end markers with loop enabled must end, not spin
        for (int a = 0; a < N; a++) wr(a, int'($urandom_range(0, 6)), 0);
        bucle = 1'b1;
        pulse_inicio();
        run(6);

`ifdef VOLUMEN_PWM_EN
        for (int a = 0; a < N; a++) wr(a, 3, 2);
        volumen = 3'd0;
        pulse_inicio();
        run(40);
        volumen = 3'd4;
        run(60);
        pulse_detener();
        run(2);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
